// File: rtl/match_event_logger_pkg.sv
// Shared defaults and width helpers for the match event logger.
package match_event_logger_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 8;

  // The level must reach DEPTH itself, so one bit more than the address width.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Timestamp FIFO: storage, pointers and fill level, with synchronous flush.
module event_fifo
  import match_event_logger_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = TS_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       valid,
  output logic                       full,
  output logic [level_w(DEPTH)-1:0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign valid = (level != '0);
  assign full  = (level == LW'(DEPTH));
  assign rd_en = pop & valid;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push & (~full | rd_en);
  assign dout  = valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; validity is tracked by level, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_en) - LW'(rd_en);
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// Logs bit-position timestamps of sequence-detector matches into a FIFO,
// with a saturating match counter and a sticky overflow flag.
module match_event_logger
  import match_event_logger_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       match_in,
  input  logic                       clr,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [TS_W-1:0]            rd_data,
  output logic [CNT_W-1:0]           match_count,
  output logic [level_w(DEPTH)-1:0]  fifo_level,
  output logic                       overflow
);

  logic [TS_W-1:0] pos;
  logic            push;
  logic            pop;
  logic            full;
  logic            drop;

  // clr wins over any match or read in the same cycle.
  assign push = match_in & ~clr;
  assign pop  = rd_ready & ~clr;
  assign drop = match_in & full & ~(rd_ready & rd_valid);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pos <= '0;
    else        pos <= pos + TS_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (clr) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (match_in && match_count != '1) match_count <= match_count + CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .W     (TS_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clr),
    .push  (push),
    .pop   (pop),
    .din   (pos),
    .dout  (rd_data),
    .valid (rd_valid),
    .full  (full),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_match_event_logger.sv
// Randomized and directed bench for match_event_logger against a queue-based model.
module tb_match_event_logger;
  import match_event_logger_pkg::*;

  localparam int DEPTH = 4;
  localparam int TS_W  = 4;
  localparam int CNT_W = 8;
  localparam int LW    = level_w(DEPTH);
  localparam int VW    = 1 + TS_W + CNT_W + LW + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic match_in = 1'b0;
  logic clr = 1'b0;
  logic rd_ready = 1'b0;
  logic            rd_valid;
  logic [TS_W-1:0] rd_data;
  logic [CNT_W-1:0] match_count;
  logic [LW-1:0]   fifo_level;
  logic            overflow;

  match_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .match_in    (match_in),
    .clr         (clr),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .match_count (match_count),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a queue of timestamps plus scalar counters.
  int q[$];
  int m_cnt = 0;
  int m_pos = 0;
  bit m_ovf = 1'b0;

  logic [VW-1:0] act;
  assign act = {rd_valid, rd_data, match_count, fifo_level, overflow};

  function automatic logic [VW-1:0] expected();
    logic [TS_W-1:0] d;
    d = '0;
    if (q.size() != 0) d = TS_W'(q[0]);
    return {q.size() != 0, d, CNT_W'(m_cnt), LW'(q.size()), m_ovf};
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt = 0;
    m_pos = 0;
    m_ovf = 1'b0;
  endtask

  // Apply the current inputs to the model, then advance the DUT one clock.
  task automatic tick();
    if (clr) begin
      q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      if (rd_ready && q.size() > 0) q.delete(0);
      if (match_in) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (q.size() < DEPTH) q.push_back(m_pos);
        else m_ovf = 1'b1;
      end
    end
    m_pos = (m_pos + 1) % (1 << TS_W);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear();
    clr = 1'b1; match_in = 1'b0; rd_ready = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic idle_until(input int target);
    for (int i = 0; i < (1 << TS_W) && m_pos != target; i++) tick();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (act !== '0) $display("FAIL reset_async: got %h expected 0", act);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (act !== '0) $display("FAIL reset_held: got %h expected 0", act);
    else n_pass++;
    reset = 1'b1;
    model_reset();
    match_in = 1'b1;
    tick();
    match_in = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== '0) $display("FAIL reset_first_pos: got valid=%b data=%0d expected valid=1 data=0", rd_valid, rd_data);
    else n_pass++;
  endtask

  task automatic test_single();
    clear();
    idle_until(5);
    match_in = 1'b1;
    tick();
    match_in = 1'b0;
    n_checks++;
    if (act !== expected() || rd_data !== 4'd5 || match_count !== 8'd1 || fifo_level !== 3'd1)
      $display("FAIL single_push: got %h expected %h (data 5)", act, expected());
    else n_pass++;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_checks++;
    if (act !== expected() || rd_valid !== 1'b0 || fifo_level !== '0)
      $display("FAIL single_pop: got %h expected %h", act, expected());
    else n_pass++;
  endtask

  task automatic test_overflow();
    int exp_ts[4];
    exp_ts = '{3, 6, 9, 12};
    clear();
    idle_until(3);
    for (int i = 0; i < 13; i++) begin
      match_in = (m_pos % 3 == 0);
      tick();
    end
    match_in = 1'b0;
    n_checks++;
    if (act !== expected() || fifo_level !== 3'd4 || overflow !== 1'b1 || match_count !== 8'd5)
      $display("FAIL overflow_state: got %h expected %h", act, expected());
    else n_pass++;
    tick();
    n_checks++;
    if (rd_data !== 4'd3) $display("FAIL hold_stable: got %0d expected 3", rd_data);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== TS_W'(exp_ts[i]))
        $display("FAIL overflow_drain%0d: got valid=%b data=%0d expected 1/%0d", i, rd_valid, rd_data, exp_ts[i]);
      else n_pass++;
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    n_checks++;
    if (act !== expected() || rd_valid !== 1'b0)
      $display("FAIL overflow_empty: got %h expected %h", act, expected());
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    int pushed;
    clear();
    match_in = 1'b1;
    repeat (4) tick();
    pushed = m_pos;
    rd_ready = 1'b1;
    tick();
    match_in = 1'b0;
    rd_ready = 1'b0;
    n_checks++;
    if (act !== expected() || fifo_level !== 3'd4 || overflow !== 1'b0)
      $display("FAIL full_push_pop: got %h expected %h", act, expected());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (act !== expected()) $display("FAIL full_drain%0d: got %h expected %h", i, act, expected());
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (rd_data !== TS_W'(pushed)) $display("FAIL full_last: got %0d expected %0d", rd_data, pushed);
        else n_pass++;
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
  endtask

  task automatic test_saturate_wrap();
    logic [TS_W-1:0] prev;
    bit seen_wrap;
    seen_wrap = 1'b0;
    clear();
    match_in = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      prev = rd_data;
      tick();
      if (rd_valid && prev == 4'd15 && rd_data == 4'd0) seen_wrap = 1'b1;
      n_checks++;
      if (act !== expected()) $display("FAIL stream_cyc%0d: got %h expected %h", i, act, expected());
      else n_pass++;
    end
    match_in = 1'b0;
    rd_ready = 1'b0;
    n_checks++;
    if (match_count !== 8'd255) $display("FAIL saturate: got %0d expected 255", match_count);
    else n_pass++;
    n_checks++;
    if (!seen_wrap) $display("FAIL ts_wrap: got no 15->0 transition expected one");
    else n_pass++;
  endtask

  task automatic test_clr_wins();
    clear();
    match_in = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (act !== expected() || overflow !== 1'b1)
      $display("FAIL clr_setup: got %h expected %h", act, expected());
    else n_pass++;
    clr = 1'b1;
    rd_ready = 1'b1;
    tick();
    clr = 1'b0;
    match_in = 1'b0;
    rd_ready = 1'b0;
    n_checks++;
    if (act !== '0) $display("FAIL clr_wins: got %h expected 0", act);
    else n_pass++;
  endtask

  task automatic test_random();
    clear();
    for (int i = 0; i < 400; i++) begin
      match_in = ($urandom_range(0, 99) < 55);
      rd_ready = ($urandom_range(0, 99) < 40);
      clr      = ($urandom_range(0, 99) < 2);
      tick();
      n_checks++;
      if (act !== expected()) $display("FAIL random_cyc%0d: got %h expected %h", i, act, expected());
      else n_pass++;
    end
    match_in = 1'b0;
    rd_ready = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear();
    match_in = 1'b1;
    repeat (3) tick();
    match_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (act !== '0) $display("FAIL reset_mid_async: got %h expected 0", act);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    match_in = 1'b1;
    tick();
    match_in = 1'b0;
    n_checks++;
    if (act !== expected() || rd_data !== '0 || fifo_level !== 3'd1)
      $display("FAIL reset_mid_push: got %h expected %h", act, expected());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_saturate_wrap();
    test_clr_wins();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning event FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter TS_W, default 16, meaning timestamp width in bits.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning match counter width in bits.
REQ-004 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port match_in  input  1  match pulse from the 110110 sequence detector's dout, one event per high cycle.
REQ-007 The block SHALL have port clr  input  1  synchronous clear of counter, FIFO and overflow flag.
REQ-008 The block SHALL have port rd_ready  input  1  consumer accepts the head entry.
REQ-009 The block SHALL have port rd_valid  output  1  FIFO non-empty, rd_data valid.
REQ-010 The block SHALL have port rd_data  output  TS_W  bit-position timestamp of the oldest unread match.
REQ-011 The block SHALL have port match_count  output  CNT_W  total matches since reset/clr, saturating.
REQ-012 The block SHALL have port fifo_level  output  clog2(DEPTH)+1  number of stored entries.
REQ-013 The block SHALL have port overflow  output  1  sticky flag, a match was dropped because the FIFO was full.

Function
REQ-014 Free-running pos counter (TS_W bits) SHALL increment by 1 every clock after reset release and wrap from 2^TS_W-1 to 0; clr SHALL NOT affect pos.
REQ-015 A cycle with match_in=1 SHALL push the pos value of that same cycle; entry visible on rd_data/rd_valid one cycle later (latency 1).
REQ-016 Consecutive high cycles of match_in SHALL each be logged as separate events (no edge detection).
REQ-017 Pop SHALL occur on a rising edge where rd_valid=1 and rd_ready=1; rd_data SHALL be head entry, FIFO order strictly FIFO.
REQ-018 rd_data SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-019 Push when full and no pop in the same cycle: entry dropped, overflow set to 1, stored contents unchanged.
REQ-020 Push and pop in the same cycle when full: both accepted, level unchanged, overflow unchanged.
REQ-021 Push and pop in the same cycle when non-full, non-empty: level unchanged; when empty, no pop occurs (rd_valid=0) and push proceeds.
REQ-022 match_count SHALL increment on every match_in=1 cycle, including dropped ones, and saturate at 2^CNT_W-1.
REQ-023 clr=1 SHALL on the next edge set match_count=0, fifo_level=0, rd_valid=0, overflow=0; a match or pop in the same cycle SHALL be ignored (clr wins).
REQ-024 overflow SHALL remain 1 until clr or reset.

Reset
REQ-025 reset=0 SHALL immediately, independent of clk, force pos=0, match_count=0, fifo_level=0, rd_valid=0, rd_data=0, overflow=0.
REQ-026 Reset asserted mid-operation SHALL discard all FIFO contents; first push after release SHALL be at pos=0 or later.

Structure
REQ-027 Default values of DEPTH, TS_W, CNT_W SHALL live in a shared package together with the level width derivation.
REQ-028 FIFO storage, pointers and level SHALL be a sub-module event_fifo; pos counter, counter, overflow and clr arbitration SHALL be in the top.

Verification
REQ-029 Reset low for 2 cycles then released -> all outputs 0; pos 0 at first edge after release.
REQ-030 match_in high in the cycle where pos=5, rd_ready=0 -> next cycle rd_valid=1, rd_data=5, match_count=1, fifo_level=1; assert rd_ready one cycle -> rd_valid=0, level=0.
REQ-031 Five single-cycle matches at pos 3,6,9,12,15, no reads, DEPTH=4 -> level=4, overflow=1, count=5; draining returns 3,6,9,12 then rd_valid=0.
REQ-032 FIFO full, match_in=1 and rd_ready=1 same cycle -> level stays 4, overflow stays 0, new timestamp appears as last read.
REQ-033 match_in held high 260 cycles with CNT_W=8 -> match_count=255; with TS_W=4, timestamps wrap 15 -> 0.
REQ-034 clr=1 coincident with match_in=1 on a full FIFO with overflow=1 -> next cycle count=0, level=0, overflow=0, rd_valid=0.
